// File: rtl/encoder_param_ctrl.sv
// rtl/encoder_param_ctrl.sv - rotary-encoder parameter browse/edit/commit controller
// Optional ENC_ACCEL_EN: same-direction edit steps inside ACCEL_WIN cycles use ACCEL_STEP.
module encoder_param_ctrl #(
  parameter int NPARAM     = 4,
  parameter int WIDTH      = 6,
  parameter int VMAX       = 63,
  parameter int RESET_VAL  = 0,
  parameter int TIMEOUT    = 27_000_000,
  parameter int ACCEL_WIN  = 2_700_000,
  parameter int ACCEL_STEP = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        step_up,
  input  logic                        step_dn,
  input  logic                        btn_press,
  output logic [$clog2(NPARAM)-1:0]   sel,
  output logic [WIDTH-1:0]            disp_val,
  output logic                        editing,
  output logic                        wr_stb,
  output logic [$clog2(NPARAM)-1:0]   wr_idx,
  output logic [NPARAM*WIDTH-1:0]     param_out
);

  localparam int SW = $clog2(NPARAM);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]    SEL_MAX = SW'(NPARAM - 1);
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH:0]   VMAX_X  = (WIDTH + 1)'(VMAX);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

  typedef enum logic [1:0] {BROWSE, EDIT, COMMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] param [NPARAM];
  logic [WIDTH-1:0] edit_val;
  logic [WIDTH-1:0] edit_nxt;
  logic [TW-1:0]    to_cnt;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   up_sum;
  logic             up_ok;
  logic             dn_ok;

  // Simultaneous up and down detents cancel out entirely.
  assign up_ok = step_up & ~step_dn;
  assign dn_ok = step_dn & ~step_up;

`ifdef ENC_ACCEL_EN
  localparam int AW = $clog2(ACCEL_WIN + 1);
  localparam logic [AW-1:0] WIN_SAT = AW'(ACCEL_WIN);
  localparam logic [AW-1:0] WIN_ACC = AW'(ACCEL_WIN - 1);

  // win_cnt holds (cycles since last edit step) - 1, parked at WIN_SAT when no recent step.
  logic [AW-1:0] win_cnt;
  logic          last_up;

  assign step = (win_cnt < WIN_ACC && last_up == up_ok) ? (WIDTH + 1)'(ACCEL_STEP)
                                                         : (WIDTH + 1)'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_cnt <= WIN_SAT;
      last_up <= 1'b0;
    end else if (state == BROWSE && btn_press) begin
      win_cnt <= WIN_SAT;
    end else if (state == EDIT && !btn_press && (up_ok || dn_ok)) begin
      win_cnt <= '0;
      last_up <= up_ok;
    end else if (win_cnt < WIN_SAT) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end
`else
  assign step = (WIDTH + 1)'(1);
`endif

  assign up_sum = {1'b0, edit_val} + step;

  always_comb begin
    edit_nxt = edit_val;
    if (up_ok)
      edit_nxt = WIDTH'((up_sum > VMAX_X) ? VMAX_X : up_sum);
    else if (dn_ok)
      edit_nxt = WIDTH'(({1'b0, edit_val} < step) ? '0 : ({1'b0, edit_val} - step));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= BROWSE;
      sel      <= '0;
      edit_val <= '0;
      wr_stb   <= 1'b0;
      wr_idx   <= '0;
      to_cnt   <= '0;
      editing  <= 1'b0;
      for (int i = 0; i < NPARAM; i++) param[i] <= RST_V;
    end else begin
      wr_stb <= 1'b0;
      case (state)
        BROWSE: begin
          if (btn_press) begin
            edit_val <= param[sel];
            to_cnt   <= '0;
            editing  <= 1'b1;
            state    <= EDIT;
          end else if (up_ok) begin
            sel <= (sel == SEL_MAX) ? '0 : sel + 1'b1;
          end else if (dn_ok) begin
            sel <= (sel == '0) ? SEL_MAX : sel - 1'b1;
          end
        end
        EDIT: begin
          if (btn_press) begin
            param[sel] <= edit_val;
            wr_stb     <= 1'b1;
            wr_idx     <= sel;
            to_cnt     <= '0;
            editing    <= 1'b0;
            state      <= COMMIT;
          end else if (up_ok || dn_ok) begin
            edit_val <= edit_nxt;
            to_cnt   <= '0;
          end else if (to_cnt == TO_LAST) begin
            editing <= 1'b0;
            state   <= BROWSE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        COMMIT:  state <= BROWSE;
        default: state <= BROWSE;
      endcase
    end
  end

  assign disp_val = editing ? edit_val : param[sel];

  for (genvar g = 0; g < NPARAM; g++) begin : g_pack
    assign param_out[g*WIDTH +: WIDTH] = param[g];
  end

endmodule
